// File: rtl/rca_n.sv
`default_nettype none
// ============================================================================
// Module   : rca_n
// Purpose  : Pipelined unsigned ripple-carry adder. The WIDTH-bit add is cut
//            into S = WIDTH/M segments of M bits. Each segment is an M-bit
//            ripple chain of full adders in its own pipeline stage. The carry
//            between segments is registered. One operand pair is accepted per
//            clock. Sum/C_out appear S edges after sampling, counting the
//            sampling edge.
// Ports    : clk   - rising-edge clock
//            rst_n - asynchronous active-low reset; clears all registers
//            A, B  - WIDTH-bit unsigned operands, sampled every rising edge
//            Sum   - registered (A+B) mod 2^WIDTH
//            C_out - registered carry out of bit WIDTH-1, aligned with Sum
// Revision : 1.0 - initial release
// ============================================================================
module rca_n #(
  parameter int WIDTH = 16,
  parameter int M     = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] Sum,
  output logic             C_out
);

  // Guard the division so a bad M is reported by the check below rather than
  // as a divide-by-zero.
  localparam int S = (M > 0) ? (WIDTH / M) : 1;

  if (M < 1 || WIDTH < 1 || (WIDTH % M) != 0) begin : g_param_check
    $error("rca_n: WIDTH (%0d) must be a positive integer multiple of M (%0d)",
           WIDTH, M);
  end

  // Aligned per-segment results and the registered carry out of each stage.
  logic [M-1:0] seg_sum   [S];
  logic         seg_carry [S];

  for (genvar j = 0; j < S; j++) begin : g_seg
    // Sum segment j is produced at the edge after stage j computes it. It
    // then waits this many extra edges so it lines up with the last stage.
    localparam int SUM_DLY = S - 1 - j;

    logic [M-1:0] a_in;
    logic [M-1:0] b_in;
    logic         carry_in;
    logic [M-1:0] add_sum;
    logic         add_carry;
    logic [M-1:0] sum_pipe [SUM_DLY+1];
    logic         carry_q;

    if (j == 0) begin : g_no_skew
      // The lowest segment adds straight from the ports with carry-in 0.
      assign a_in     = A[M-1:0];
      assign b_in     = B[M-1:0];
      assign carry_in = 1'b0;
    end else begin : g_skew
      // Operand segment j is delayed j edges. It then meets the carry that
      // stage j-1 registered for the same operand pair.
      logic [M-1:0] a_dly [j];
      logic [M-1:0] b_dly [j];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int k = 0; k < j; k++) begin
            a_dly[k] <= '0;
            b_dly[k] <= '0;
          end
        end else begin
          a_dly[0] <= A[j*M +: M];
          b_dly[0] <= B[j*M +: M];
          for (int k = 1; k < j; k++) begin
            a_dly[k] <= a_dly[k-1];
            b_dly[k] <= b_dly[k-1];
          end
        end
      end

      assign a_in     = a_dly[j-1];
      assign b_in     = b_dly[j-1];
      assign carry_in = seg_carry[j-1];
    end

    // M chained full adders, pure ripple. Each bit's carry feeds the next bit.
    always_comb begin : p_ripple
      logic c;
      add_sum   = '0;
      c         = carry_in;
      for (int i = 0; i < M; i++) begin
        add_sum[i] = a_in[i] ^ b_in[i] ^ c;
        c          = (a_in[i] & b_in[i]) | (c & (a_in[i] ^ b_in[i]));
      end
      add_carry = c;
    end

    // Stage register (sum_pipe[0], carry_q) followed by the sum deskew line.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int k = 0; k <= SUM_DLY; k++) begin
          sum_pipe[k] <= '0;
        end
        carry_q <= 1'b0;
      end else begin
        sum_pipe[0] <= add_sum;
        for (int k = 1; k <= SUM_DLY; k++) begin
          sum_pipe[k] <= sum_pipe[k-1];
        end
        carry_q <= add_carry;
      end
    end

    assign seg_sum[j]   = sum_pipe[SUM_DLY];
    assign seg_carry[j] = carry_q;
  end

  // Every segment tail is a register, so Sum is glitch-free between edges.
  always_comb begin
    Sum = '0;
    for (int j = 0; j < S; j++) begin
      Sum[j*M +: M] = seg_sum[j];
    end
  end

  assign C_out = seg_carry[S-1];

endmodule
`default_nettype wire

// File: tb/tb_rca_n.sv
`default_nettype none
// ============================================================================
// Module   : tb_rca_n
// Purpose  : Scoreboard bench for rca_n. A sampler pushes A+B (17-bit plain
//            arithmetic) into a queue, tagged with the edge on which the
//            result is due. A monitor compares DUT outputs against the queue
//            on every falling edge, and expects zero while reset is held or
//            before the first post-reset result is due.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_rca_n;

  localparam int WIDTH = 16;
  localparam int M     = 4;
  localparam int S     = WIDTH / M;

  logic             clk;
  logic             rst_n;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [WIDTH-1:0] Sum;
  logic             C_out;

  rca_n #(.WIDTH(WIDTH), .M(M)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .A     (A),
    .B     (B),
    .Sum   (Sum),
    .C_out (C_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int unsigned    due;
    logic [WIDTH:0] val;
  } exp_t;

  exp_t        exp_q [$];
  int unsigned edge_cnt = 0;
  int          n_checks = 0;
  int          n_fail   = 0;
  int          n_pops   = 0;
  bit          mon_en   = 1'b0;

  task automatic check(input string name, input logic [WIDTH:0] exp);
    n_checks++;
    if ({C_out, Sum} !== exp) begin
      n_fail++;
      $display("FAIL %s at edge %0d: got C_out=%b Sum=%h, expected C_out=%b Sum=%h",
               name, edge_cnt, C_out, Sum, exp[WIDTH], exp[WIDTH-1:0]);
    end
  endtask

  // Reference: each pair sampled on edge n yields the unsigned sum after
  // edge n+S-1.
  always @(posedge clk) begin
    edge_cnt++;
    if (rst_n) begin
      exp_t e;
      e.due = edge_cnt + S - 1;
      e.val = {1'b0, A} + {1'b0, B};
      exp_q.push_back(e);
    end
  end

  // Reset discards everything still in flight.
  always @(negedge rst_n) exp_q.delete();

  // Monitor.
  always @(negedge clk) begin
    if (mon_en) begin
      if (!rst_n) begin
        check("reset_hold", '0);
      end else if (exp_q.size() > 0 && exp_q[0].due == edge_cnt) begin
        exp_t e;
        e = exp_q.pop_front();
        n_pops++;
        check("result", e.val);
      end else if (exp_q.size() > 0 && exp_q[0].due < edge_cnt) begin
        exp_t e;
        e = exp_q.pop_front();
        n_checks++;
        n_fail++;
        $display("FAIL scoreboard_order: entry due at edge %0d unchecked at edge %0d",
                 e.due, edge_cnt);
      end else begin
        check("post_reset_zero", '0);
      end
    end
  end

  task automatic drive(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    @(negedge clk);
    A = a;
    B = b;
  endtask

  // Short low pulse inside one clock period.
  task automatic pulse_reset();
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check("async_reset_clear", '0);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b1;
    A     = '1;
    B     = '1;
    #2 rst_n = 1'b0;
    mon_en = 1'b1;
    #1 check("async_reset_start", '0);
    repeat (3) @(negedge clk);

    // Release with the latency probe already on the inputs.
    @(negedge clk);
    A     = 16'd16;
    B     = 16'd16;
    rst_n = 1'b1;
    drive(16'd55, 16'd65);
    drive(16'd5, 16'd2);
    drive(16'd100, 16'd100);
    repeat (6) @(negedge clk);

    // Carry ripple across every segment and across single boundaries.
    drive(16'hFFFF, 16'h0001);
    drive(16'hFFFF, 16'hFFFF);
    drive(16'h0FFF, 16'h0001);
    drive(16'h00F0, 16'h0010);
    drive(16'h8000, 16'h8000);
    drive(16'h7FFF, 16'h0001);
    drive(16'h0000, 16'h0000);
    drive(16'hF0F0, 16'h0F10);

    // Reset mid-stream with four results in flight.
    drive(16'h1234, 16'h4321);
    drive(16'hAAAA, 16'h5555);
    drive(16'hFFFE, 16'h0003);
    drive(16'h0F0F, 16'hF0F1);
    pulse_reset();
    drive(16'h0101, 16'h0202);
    drive(16'h3000, 16'h5000);

    // Random traffic, with some all-ones operands to force long carries.
    for (int i = 0; i < 300; i++) begin
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
      a = WIDTH'($urandom);
      b = WIDTH'($urandom);
      if ($urandom_range(0, 7) == 0) a = '1;
      if ($urandom_range(0, 7) == 0) b = WIDTH'(~a + 1'b1);
      drive(a, b);
      if (i == 150) pulse_reset();
    end

    repeat (S + 2) @(negedge clk);

    n_checks++;
    if (n_pops < 300) begin
      n_fail++;
      $display("FAIL scoreboard_activity: got %0d results, expected at least 300", n_pops);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/rca_n.md
# rca_n

Pipelined N-bit ripple-carry adder. The WIDTH-bit addition is split into WIDTH/M segments of M bits. Each segment is a ripple chain of full adders in its own pipeline stage. The block accepts one operand pair per clock and returns the sum and carry-out a fixed number of cycles later. It is a generic datapath adder for use wherever a registered, high-throughput unsigned add is needed.

## Interface
- WIDTH, 16, operand and sum width in bits.
- M, 4, segment width in bits (bits per pipeline stage). WIDTH must be an integer multiple of M. Elaboration must fail otherwise.
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset. One clock; reset is asynchronous and active-low.
- A  input  WIDTH  unsigned operand A, sampled every rising edge.
- B  input  WIDTH  unsigned operand B, sampled every rising edge.
- Sum  output  WIDTH  registered sum (A+B) mod 2^WIDTH.
- C_out  output  1  registered carry out of bit WIDTH-1.

## Operation
- S = WIDTH/M pipeline stages. Stage j (0..S-1) adds bits [j*M +: M] of A and B, plus the carry registered by stage j-1. Stage 0 uses carry-in 0.
- Each stage is a ripple chain of M full adders. No carry-lookahead.
- Operand skew:
  - Upper operand segments travel through delay registers so each segment reaches its adder in the same cycle as its carry.
  - Lower sum segments travel through delay registers so all Sum bits for one operand pair emerge together.
- C_out is the carry out of stage S-1, aligned with the same operand pair's Sum.
- Arithmetic is unsigned with no saturation. Overflow wraps modulo 2^WIDTH, and C_out=1 flags it.
- No handshake and no valid signal. A new operand pair is accepted every cycle at full throughput.
- Reset:
  - rst_n low asynchronously clears every pipeline, skew and output register. Sum=0 and C_out=0 immediately, without waiting for a clock.
  - Assertion mid-stream discards all in-flight results.
  - After release, outputs read 0 (the result of zeroed stages) until the first post-reset operand pair emerges.
- M=WIDTH is legal: a single stage of full ripple with latency 1.

## Timing
- Operands present at rising edge n produce Sum/C_out that are valid after rising edge n+S-1. This is a latency of S edges, counting the sampling edge.
- For WIDTH=16, M=4 (S=4): operands sampled at edge n appear after edge n+3.
- Outputs change only on rising clk edges or on rst_n assertion. They are stable for the whole cycle in between.
- Back-to-back operand pairs yield results on consecutive cycles, in order, with no bubbles.
- Critical path is one M-bit ripple plus register setup. It is independent of WIDTH.

## Test plan
- Reset: drive rst_n=0 with A=B=0xFFFF while clocking -> Sum=0, C_out=0 throughout. Sum and C_out clear asynchronously, before the next edge.
- Latency: A=16, B=16 sampled at edge n -> Sum=32, C_out=0 after edge n+3. Outputs are 0 before that.
- Stream:
  - Drive A/B = 16/16, 55/65, 5/2 and 100/100 on consecutive edges, then hold 100/100.
  - Sum must read 32, 120, 7, 200 on four consecutive cycles.
  - Sum must then stay at 200.
- Full carry ripple across all segments: A=0xFFFF, B=0x0001 -> Sum=0x0000, C_out=1. A=0xFFFF, B=0xFFFF -> Sum=0xFFFE, C_out=1.
- Segment boundary carry: A=0x0FFF, B=0x0001 -> Sum=0x1000, C_out=0. A=0x00F0, B=0x0010 -> Sum=0x0100.
- Reset mid-stream:
  - Pulse rst_n low for a partial cycle while four results are in flight -> outputs go to 0 at once.
  - None of the in-flight sums ever appear.
  - The first operand pair sampled after release emerges 4 edges later.
